debounce_sync: RTL and testbench

DEBOUNCE_SYNC -- requirements
Module: debounce_sync

---
 rtl/debounce_pkg.sv | 28 ++
 rtl/sync_chain.sv | 34 +++
 rtl/debounce_sync.sv | 125 ++++++++++++
 tb/tb_debounce_sync.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce/synchronizer block.
//   state_e        : 2-bit FSM encoding (LOW=00, CHK_H=01, HIGH=11, CHK_L=10)
//   *_MIN / *_MAX  : legal parameter limits
//   *_DEF          : default parameter values
//   cnt_width()    : qualification counter width for a given STABLE_CYCLES
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW   = 2'b00,
    ST_CHK_H = 2'b01,
    ST_HIGH  = 2'b11,
    ST_CHK_L = 2'b10
  } state_e;

  localparam int SYNC_STAGES_MIN   = 2;
  localparam int SYNC_STAGES_MAX   = 4;
  localparam int SYNC_STAGES_DEF   = 2;
  localparam int STABLE_CYCLES_MIN = 2;
  localparam int STABLE_CYCLES_MAX = 255;
  localparam int STABLE_CYCLES_DEF = 8;

  // Wide enough to hold STABLE_CYCLES; the counter only ever reaches
  // STABLE_CYCLES-1 because every state exit clears it.
  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous level.
//   clk : sampling clock (rising edge)
//   rst : asynchronous active-low clear of every stage
//   d   : asynchronous input
//   q   : synchronized output (last stage)
module sync_chain
  import debounce_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Synchronizes an asynchronous, bouncing level and only lets q follow it
// once the synchronized value has held for STABLE_CYCLES consecutive cycles.
//   clk   : single clock, rising edge
//   rst   : asynchronous active-low reset
//   d_raw : asynchronous, possibly bouncing input level
//   q     : debounced level (registered)
//   rise  : one-cycle pulse after q goes 0->1 (registered)
//   fall  : one-cycle pulse after q goes 1->0 (registered)
//   busy  : high while a candidate transition is being qualified (registered)
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_LOW   | q=0, input agrees with q
// ST_CHK_H | q=0, input went high, counting stable-high cycles
// ST_HIGH  | q=1, input agrees with q
// ST_CHK_L | q=1, input went low, counting stable-low cycles
module debounce_sync
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic d_raw,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int CNT_W = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync_in;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync_chain (
    .clk(clk),
    .rst(rst),
    .d  (d_raw),
    .q  (sync_in)
  );

  // The entry cycle already counts as the first stable sample, so the
  // check states start at 1 and exit on STABLE_CYCLES-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      ST_LOW: begin
        if (sync_in) begin
          state_d = ST_CHK_H;
          cnt_d   = CNT_ONE;
        end
      end
      ST_CHK_H: begin
        if (!sync_in) begin
          state_d = ST_LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!sync_in) begin
          state_d = ST_CHK_L;
          cnt_d   = CNT_ONE;
        end
      end
      ST_CHK_L: begin
        if (sync_in) begin
          state_d = ST_HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOW;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_LOW;
      end
    endcase

    // Outputs are decoded from the next state so they land in flops
    // on the same edge as the state itself.
    q_d    = (state_d == ST_HIGH) || (state_d == ST_CHK_L);
    busy_d = (state_d == ST_CHK_H) || (state_d == ST_CHK_L);
    rise_d = q_d & ~q_q;
    fall_d = ~q_d & q_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign q    = q_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: default instance plus a SYNC_STAGES=3,
// STABLE_CYCLES=2 instance sharing the same stimulus.
module tb_debounce_sync;

  logic clk   = 1'b0;
  logic rst   = 1'b0;
  logic d_raw = 1'b0;
  logic q0, rise0, fall0, busy0;
  logic q1, rise1, fall1, busy1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debounce_sync dut (
    .clk  (clk),
    .rst  (rst),
    .d_raw(d_raw),
    .q    (q0),
    .rise (rise0),
    .fall (fall0),
    .busy (busy0)
  );

  debounce_sync #(
    .SYNC_STAGES  (3),
    .STABLE_CYCLES(2)
  ) dut2 (
    .clk  (clk),
    .rst  (rst),
    .d_raw(d_raw),
    .q    (q1),
    .rise (rise1),
    .fall (fall1),
    .busy (busy1)
  );

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: keep the raw samples taken at each edge. The FSM
  // sees the sample taken SYNC_STAGES edges earlier; q flips whenever the
  // last STABLE_CYCLES samples the FSM has seen all disagree with q.
  localparam int NI = 2;
  localparam int HW = 16;
  int   s_p  [NI] = '{2, 3};
  int   st_p [NI] = '{8, 2};
  logic hist   [NI][HW];
  logic m_q    [NI];
  logic m_rise [NI];
  logic m_fall [NI];
  logic m_busy [NI];
  logic all_opp;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        for (int j = 0; j < HW; j++) hist[i][j] = 1'b0;
        m_q[i]    = 1'b0;
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        m_busy[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        for (int j = HW - 1; j > 0; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = d_raw;
        all_opp = 1'b1;
        for (int j = 0; j < st_p[i]; j++) begin
          if (hist[i][s_p[i] + j] == m_q[i]) all_opp = 1'b0;
        end
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        if (all_opp) begin
          m_q[i]    = ~m_q[i];
          m_rise[i] = m_q[i];
          m_fall[i] = ~m_q[i];
        end
        m_busy[i] = (hist[i][s_p[i]] != m_q[i]);
      end
    end
  end

  always @(negedge clk) begin
    check("m0_q",    q0,    m_q[0]);
    check("m0_rise", rise0, m_rise[0]);
    check("m0_fall", fall0, m_fall[0]);
    check("m0_busy", busy0, m_busy[0]);
    check("m1_q",    q1,    m_q[1]);
    check("m1_rise", rise1, m_rise[1]);
    check("m1_fall", fall1, m_fall[1]);
    check("m1_busy", busy1, m_busy[1]);
  end

  logic vec [12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  int   n_rise, n_fall, last_pulse;
  logic prev_rise, prev_fall;

  initial begin
    // Reset state
    rst   = 1'b0;
    d_raw = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_q",    q0,    1'b0);
    check("rst_rise", rise0, 1'b0);
    check("rst_fall", fall0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Step to 1: default q after edge 10; small instance q after edge 5
    d_raw = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      check("step_q",    q0,    logic'(e >= 10));
      check("step_rise", rise0, logic'(e == 10));
      check("step_busy", busy0, logic'(e >= 3 && e <= 9));
      check("step2_q",   q1,    logic'(e >= 5));
    end

    // Bouncing release from HIGH: final low run starts at edge 4
    for (int e = 1; e <= 16; e++) begin
      d_raw = (e <= 12) ? vec[e-1] : 1'b0;
      @(negedge clk);
      check("rel_q",    q0,    logic'(e < 13));
      check("rel_fall", fall0, logic'(e == 13));
      check("rel_busy", busy0, logic'(e == 4 || (e >= 6 && e <= 12)));
    end
    d_raw = 1'b0;
    repeat (6) @(negedge clk);

    // Glitch of 5 cycles from LOW is rejected
    for (int e = 1; e <= 20; e++) begin
      d_raw = (e <= 5);
      @(negedge clk);
      check("gl_q",    q0,    1'b0);
      check("gl_edge", rise0 | fall0, 1'b0);
    end
    check("gl_busy_end", busy0, 1'b0);

    // Square wave of period 2*STABLE_CYCLES
    n_rise = 0;
    n_fall = 0;
    last_pulse = 0;
    prev_rise = 1'b0;
    prev_fall = 1'b0;
    for (int e = 0; e < 76; e++) begin
      d_raw = (e < 64) ? ((e % 16) < 8) : 1'b0;
      @(negedge clk);
      check("sq_overlap", rise0 & fall0, 1'b0);
      if (rise0) begin
        check("sq_rise_width", prev_rise, 1'b0);
        check("sq_alt_rise", logic'(last_pulse == 1), 1'b0);
        n_rise++;
        last_pulse = 1;
      end
      if (fall0) begin
        check("sq_fall_width", prev_fall, 1'b0);
        check("sq_alt_fall", logic'(last_pulse == 2), 1'b0);
        n_fall++;
        last_pulse = 2;
      end
      prev_rise = rise0;
      prev_fall = fall0;
    end
    check_int("sq_rises", n_rise, 4);
    check_int("sq_falls", n_fall, 4);

    // Async reset while HIGH, then requalify after release
    d_raw = 1'b1;
    repeat (14) @(negedge clk);
    check("pre_rst_q", q0, 1'b1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_q",    q0,    1'b0);
    check("arst_fall", fall0, 1'b0);
    check("arst_busy", busy0, 1'b0);
    check("arst_q2",   q1,    1'b0);
    @(negedge clk);
    check("arst_q_hold",    q0,    1'b0);
    check("arst_fall_hold", fall0, 1'b0);
    rst = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      check("post_rise", rise0, logic'(e == 10));
      check("post_q",    q0,    logic'(e >= 10));
      check("post_busy", busy0, logic'(e >= 3 && e <= 9));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
